// File: rtl/tsqr_stream_loader.sv
// Streaming tile loader for the TSQR core: packs valid/ready beats into a two-bank ping-pong buffer.
// Optional macro TSQR_LOADER_LANE_REV_EN reverses lane order within each channel on the write path.
module tsqr_stream_loader #(
    parameter int DATA_W         = 32,
    parameter int LANES          = 4,
    parameter int NUM_CH         = 2,
    parameter int BEATS_PER_TILE = 2,
    parameter int CNT_WIDTH      = 16,
    parameter int ADDR_W         = (BEATS_PER_TILE > 1) ? $clog2(BEATS_PER_TILE) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [CNT_WIDTH-1:0]           tile_no,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [NUM_CH*LANES*DATA_W-1:0] s_data,
    output logic [1:0]                     wr_en,
    output logic [ADDR_W-1:0]              wr_addr,
    output logic [NUM_CH*LANES*DATA_W-1:0] wr_data,
    output logic [1:0]                     bank_full,
    input  logic [1:0]                     bank_release,
    output logic [CNT_WIDTH-1:0]           tile_cnt,
    output logic                           busy,
    output logic                           load_done
);

    localparam int BUS_W = NUM_CH * LANES * DATA_W;
    localparam logic [ADDR_W-1:0] BEAT_LAST = ADDR_W'(BEATS_PER_TILE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [BUS_W-1:0] lane_map(input logic [BUS_W-1:0] din);
        logic [BUS_W-1:0] dout;
`ifdef TSQR_LOADER_LANE_REV_EN
        dout = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < LANES; k++) begin
                dout[(c*LANES + LANES-1-k)*DATA_W +: DATA_W] = din[(c*LANES + k)*DATA_W +: DATA_W];
            end
        end
`else
        dout = din;
`endif
        return dout;
    endfunction

    state_t                 state_r, state_s;
    logic                   sel_r, sel_s;
    logic [ADDR_W-1:0]      beat_r, beat_s;
    logic [CNT_WIDTH-1:0]   tile_cnt_r, tile_cnt_s;
    logic [CNT_WIDTH-1:0]   tile_no_r, tile_no_s;
    logic [1:0]             bank_full_r, bank_full_s;
    logic [1:0]             rel_pend_r, rel_pend_s;
    logic [1:0]             wr_en_r, wr_en_s;
    logic [ADDR_W-1:0]      wr_addr_r, wr_addr_s;
    logic [BUS_W-1:0]       wr_data_r, wr_data_s;
    logic                   load_done_r, load_done_s;
    logic [1:0]             fill_s;
    logic [1:0]             rel_s;
    logic                   accept_s;

    assign s_ready  = (state_r == ST_LOAD) & ~bank_full_r[sel_r];
    assign accept_s = s_valid & s_ready;

    // Next-state, write-path and bank occupancy logic
    always_comb begin
        state_s     = state_r;
        sel_s       = sel_r;
        beat_s      = beat_r;
        tile_cnt_s  = tile_cnt_r;
        tile_no_s   = tile_no_r;
        wr_en_s     = 2'b00;
        wr_addr_s   = wr_addr_r;
        wr_data_s   = wr_data_r;
        load_done_s = 1'b0;
        fill_s      = 2'b00;
        bank_full_s = bank_full_r;
        rel_pend_s  = 2'b00;
        rel_s       = bank_release | rel_pend_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    tile_cnt_s = '0;
                    tile_no_s  = tile_no;
                    if (tile_no != '0) begin
                        state_s = ST_LOAD;
                    end else begin
                        load_done_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    wr_en_s   = sel_r ? 2'b10 : 2'b01;
                    wr_addr_s = beat_r;
                    wr_data_s = lane_map(s_data);
                    if (beat_r == BEAT_LAST) begin
                        beat_s     = '0;
                        fill_s     = wr_en_s;
                        tile_cnt_s = tile_cnt_r + 1'b1;
                        sel_s      = ~sel_r;
                        if (tile_cnt_s == tile_no_r) begin
                            state_s     = ST_DONE;
                            load_done_s = 1'b1;
                        end else begin
                            state_s = ST_LOAD;
                        end
                    end else begin
                        beat_s = beat_r + 1'b1;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // A release landing on a tile-completion edge is deferred one cycle so both events are seen.
        if (fill_s != 2'b00) begin
            bank_full_s = bank_full_r | fill_s;
            rel_pend_s  = rel_s & bank_full_s;
        end else begin
            bank_full_s = bank_full_r & ~rel_s;
            rel_pend_s  = 2'b00;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            sel_r       <= 1'b0;
            beat_r      <= '0;
            tile_cnt_r  <= '0;
            tile_no_r   <= '0;
            bank_full_r <= 2'b00;
            rel_pend_r  <= 2'b00;
            wr_en_r     <= 2'b00;
            wr_addr_r   <= '0;
            wr_data_r   <= '0;
            load_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            sel_r       <= sel_s;
            beat_r      <= beat_s;
            tile_cnt_r  <= tile_cnt_s;
            tile_no_r   <= tile_no_s;
            bank_full_r <= bank_full_s;
            rel_pend_r  <= rel_pend_s;
            wr_en_r     <= wr_en_s;
            wr_addr_r   <= wr_addr_s;
            wr_data_r   <= wr_data_s;
            load_done_r <= load_done_s;
        end
    end

    assign wr_en     = wr_en_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign bank_full = bank_full_r;
    assign tile_cnt  = tile_cnt_r;
    assign busy      = (state_r != ST_IDLE);
    assign load_done = load_done_r;

endmodule

// File: tb/tb_tsqr_stream_loader.sv
// Directed self-checking bench for tsqr_stream_loader (default parameters).
module tb_tsqr_stream_loader;

    localparam int BW = 2 * 4 * 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   tile_no;
    logic          s_valid;
    logic          s_ready;
    logic [BW-1:0] s_data;
    logic [1:0]    wr_en;
    logic [0:0]    wr_addr;
    logic [BW-1:0] wr_data;
    logic [1:0]    bank_full;
    logic [1:0]    bank_release;
    logic [15:0]   tile_cnt;
    logic          busy;
    logic          load_done;

    int vectors    = 0;
    int miscompares = 0;

    logic [BW-1:0] dv [6];
    logic [BW-1:0] mac_in;
    logic [BW-1:0] mac_exp;

    tsqr_stream_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .tile_no      (tile_no),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .bank_full    (bank_full),
        .bank_release (bank_release),
        .tile_cnt     (tile_cnt),
        .busy         (busy),
        .load_done    (load_done)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] exp_map(input logic [BW-1:0] d);
        logic [BW-1:0] r;
`ifdef TSQR_LOADER_LANE_REV_EN
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 4; k++) begin
                r[(c*4 + 3-k)*32 +: 32] = d[(c*4 + k)*32 +: 32];
            end
        end
`else
        r = d;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".s_ready"},   BW'(s_ready),   BW'(1'b0));
        chk({tag, ".wr_en"},     BW'(wr_en),     BW'(2'b00));
        chk({tag, ".wr_addr"},   BW'(wr_addr),   BW'(1'b0));
        chk({tag, ".wr_data"},   wr_data,        BW'(1'b0));
        chk({tag, ".bank_full"}, BW'(bank_full), BW'(2'b00));
        chk({tag, ".tile_cnt"},  BW'(tile_cnt),  BW'(16'd0));
        chk({tag, ".busy"},      BW'(busy),      BW'(1'b0));
        chk({tag, ".load_done"}, BW'(load_done), BW'(1'b0));
    endtask

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic beat(input logic [BW-1:0] d, input logic [1:0] en, input logic addr,
                        input logic [1:0] rel);
        s_valid      = 1'b1;
        s_data       = d;
        bank_release = rel;
        chk("beat.s_ready", BW'(s_ready), BW'(1'b1));
        @(posedge clk);
        @(negedge clk);
        s_valid      = 1'b0;
        bank_release = 2'b00;
        chk("beat.wr_en",   BW'(wr_en),   BW'(en));
        chk("beat.wr_addr", BW'(wr_addr), BW'(addr));
        chk("beat.wr_data", wr_data,      exp_map(d));
    endtask

    task automatic pulse_start(input logic [15:0] n);
        start   = 1'b1;
        tile_no = n;
        @(negedge clk);
        start   = 1'b0;
        tile_no = 16'd7;
    endtask

    task automatic release_bank(input logic [1:0] m);
        bank_release = m;
        @(negedge clk);
        bank_release = 2'b00;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; tile_no = 16'd0; s_valid = 1'b0;
        s_data = '0; bank_release = 2'b00;
        dv[0] = {128'hC0400000_C0000000_C0E00000_C0000000, 128'h41100000_40000000_3F800000_40000000};
        for (int k = 1; k < 6; k++) begin
            dv[k] = {4{32'hC000_0000 + 32'(k), 32'h4000_0000 + 32'(k*3)}};
        end
        mac_in  = {128'hC0800000_C0400000_C0000000_BF800000, 128'h3F800000_40000000_40400000_40800000};
`ifdef TSQR_LOADER_LANE_REV_EN
        mac_exp = {128'hBF800000_C0000000_C0400000_C0800000, 128'h40800000_40400000_40000000_3F800000};
`else
        mac_exp = mac_in;
`endif

        @(negedge clk);
        chk_zero("por");
        rst = 1'b1;
        @(negedge clk);

        // Basic load of three tiles with one stall on bank0
        pulse_start(16'd3);
        chk("basic.busy", BW'(busy), BW'(1'b1));
        beat(dv[0], 2'b01, 1'b0, 2'b00);
        chk("basic.full0", BW'(bank_full), BW'(2'b00));
        beat(dv[1], 2'b01, 1'b1, 2'b00);
        chk("basic.full1", BW'(bank_full), BW'(2'b01));
        chk("basic.cnt1",  BW'(tile_cnt),  BW'(16'd1));
        beat(dv[2], 2'b10, 1'b0, 2'b00);
        beat(dv[3], 2'b10, 1'b1, 2'b00);
        chk("basic.full3", BW'(bank_full), BW'(2'b11));
        chk("basic.cnt3",  BW'(tile_cnt),  BW'(16'd2));
        chk("basic.stall", BW'(s_ready),   BW'(1'b0));
        s_valid = 1'b1; s_data = dv[4];
        @(negedge clk);
        chk("basic.nowr",   BW'(wr_en),   BW'(2'b00));
        chk("basic.stall2", BW'(s_ready), BW'(1'b0));
        s_valid = 1'b0;
        release_bank(2'b01);
        chk("basic.relfull", BW'(bank_full), BW'(2'b10));
        chk("basic.relrdy",  BW'(s_ready),   BW'(1'b1));
        beat(dv[4], 2'b01, 1'b0, 2'b00);
        beat(dv[5], 2'b01, 1'b1, 2'b00);
        chk("basic.done",    BW'(load_done), BW'(1'b1));
        chk("basic.cnt",     BW'(tile_cnt),  BW'(16'd3));
        chk("basic.busyd",   BW'(busy),      BW'(1'b1));
        @(negedge clk);
        chk("basic.done0",   BW'(load_done), BW'(1'b0));
        chk("basic.idle",    BW'(busy),      BW'(1'b0));
        chk("basic.cnthold", BW'(tile_cnt),  BW'(16'd3));
        chk("basic.wren0",   BW'(wr_en),     BW'(2'b00));

        // Backpressure, ignored start, simultaneous release and fill
        do_reset();
        pulse_start(16'd4);
        beat(dv[0], 2'b01, 1'b0, 2'b00);
        beat(dv[1], 2'b01, 1'b1, 2'b00);
        beat(dv[2], 2'b10, 1'b0, 2'b00);
        beat(dv[3], 2'b10, 1'b1, 2'b00);
        chk("bp.full",  BW'(bank_full), BW'(2'b11));
        chk("bp.ready", BW'(s_ready),   BW'(1'b0));
        pulse_start(16'd1);
        chk("bp.ign.busy", BW'(busy),     BW'(1'b1));
        chk("bp.ign.cnt",  BW'(tile_cnt), BW'(16'd2));
        release_bank(2'b01);
        chk("bp.relrdy",  BW'(s_ready),   BW'(1'b1));
        chk("bp.relfull", BW'(bank_full), BW'(2'b10));
        beat(dv[4], 2'b01, 1'b0, 2'b00);
        beat(dv[5], 2'b01, 1'b1, 2'b10);
        chk("sim.full11", BW'(bank_full), BW'(2'b11));
        chk("sim.cnt",    BW'(tile_cnt),  BW'(16'd3));
        chk("sim.rdy0",   BW'(s_ready),   BW'(1'b0));
        @(negedge clk);
        chk("sim.full01", BW'(bank_full), BW'(2'b01));
        chk("sim.rdy1",   BW'(s_ready),   BW'(1'b1));
        beat(dv[2], 2'b10, 1'b0, 2'b00);
        beat(dv[3], 2'b10, 1'b1, 2'b00);
        chk("bp.done", BW'(load_done), BW'(1'b1));
        chk("bp.cnt",  BW'(tile_cnt),  BW'(16'd4));
        chk("bp.fulld", BW'(bank_full), BW'(2'b11));
        @(negedge clk);
        chk("bp.idle", BW'(busy), BW'(1'b0));
        release_bank(2'b01);
        chk("rel.full", BW'(bank_full), BW'(2'b10));
        release_bank(2'b01);
        chk("rel.empty", BW'(bank_full), BW'(2'b10));

        // Zero-tile start
        pulse_start(16'd0);
        chk("zero.done", BW'(load_done), BW'(1'b1));
        chk("zero.busy", BW'(busy),      BW'(1'b0));
        chk("zero.wren", BW'(wr_en),     BW'(2'b00));
        chk("zero.cnt",  BW'(tile_cnt),  BW'(16'd0));
        @(negedge clk);
        chk("zero.done0", BW'(load_done), BW'(1'b0));
        chk("zero.wren1", BW'(wr_en),     BW'(2'b00));

        // Reset in the middle of tile 1
        do_reset();
        pulse_start(16'd2);
        beat(dv[0], 2'b01, 1'b0, 2'b00);
        beat(dv[1], 2'b01, 1'b1, 2'b00);
        beat(dv[2], 2'b10, 1'b0, 2'b00);
        #2;
        rst = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pulse_start(16'd1);
        beat(mac_in, 2'b01, 1'b0, 2'b00);
        chk("lane.wr_data", wr_data, mac_exp);
        beat(dv[1], 2'b01, 1'b1, 2'b00);
        chk("fresh.done", BW'(load_done), BW'(1'b1));
        chk("fresh.cnt",  BW'(tile_cnt),  BW'(16'd1));
        chk("fresh.full", BW'(bank_full), BW'(2'b01));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
